alu_16bit_extended: RTL and testbench

- 16-bit multi-function ALU covering arithmetic, logic, compare, shift, bit-mask, GCD/LCM/power, Hamming distance and fixed-point trig.
- Opcode is 8 bits.
- Sits as a clocked execution unit behind a simple valid handshake.
- Most ops finish in one cycle; GCD, LCM and POW run iteratively in a sub-unit.

---
 rtl/alu16_pkg.sv | 81 ++++++++
 rtl/alu16_iter_unit.sv | 142 ++++++++++++++
 rtl/alu_16bit_extended.sv | 145 ++++++++++++++
 tb/tb_alu_16bit_extended.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu16_pkg.sv
// Shared opcodes, trig tables and small bit-counting helpers for the 16-bit extended ALU.
package alu16_pkg;

    typedef enum logic [7:0] {
        OpAdd      = 8'h00,
        OpSub      = 8'h01,
        OpMul      = 8'h02,
        OpDiv      = 8'h03,
        OpMod      = 8'h04,
        OpAnd      = 8'h08,
        OpOr       = 8'h09,
        OpXor      = 8'h0A,
        OpNor      = 8'h0B,
        OpNand     = 8'h0C,
        OpXnor     = 8'h0D,
        OpGt       = 8'h10,
        OpEq       = 8'h11,
        OpLt       = 8'h12,
        OpGcd      = 8'h26,
        OpLcm      = 8'h27,
        OpHamming  = 8'h28,
        OpShl      = 8'h30,
        OpShr      = 8'h31,
        OpAsr      = 8'h32,
        OpMaskHi   = 8'h38,
        OpSetLo    = 8'h39,
        OpFlipAlt  = 8'h3A,
        OpAndAlias = 8'h3C,
        OpOrAlias  = 8'h3D,
        OpInc      = 8'h40,
        OpDec      = 8'h41,
        OpAbs      = 8'h50,
        OpPow      = 8'h51,
        OpSin      = 8'h52,
        OpCos      = 8'h53,
        OpTan      = 8'h54
    } opcode_e;

    localparam logic [15:0] Q14One = 16'd16384;
    localparam logic [15:0] SatPos = 16'h7FFF;

    // Indexed by floor(min(angle, 90) / 15); entry 7 is never selected.
    localparam logic [7:0][15:0] SinLut = {
        Q14One, Q14One, 16'd15826, 16'd14189, 16'd11585, 16'd8192, 16'd4240, 16'd0
    };
    localparam logic [7:0][15:0] TanLut = {
        SatPos, SatPos, SatPos, 16'd28378, Q14One, 16'd9459, 16'd4390, 16'd0
    };

    function automatic logic [2:0] trig_index(input logic [15:0] deg);
        logic [2:0] idx;
        if (deg >= 16'd90)      idx = 3'd6;
        else if (deg >= 16'd75) idx = 3'd5;
        else if (deg >= 16'd60) idx = 3'd4;
        else if (deg >= 16'd45) idx = 3'd3;
        else if (deg >= 16'd30) idx = 3'd2;
        else if (deg >= 16'd15) idx = 3'd1;
        else                    idx = 3'd0;
        return idx;
    endfunction

    function automatic logic [4:0] pop16(input logic [15:0] x);
        logic [4:0] cnt;
        cnt = 5'd0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + {4'd0, x[i]};
        end
        return cnt;
    endfunction

    // Count of trailing zeros; a zero input yields 0.
    function automatic logic [3:0] ctz16(input logic [15:0] x);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (x[i]) n = 4'(i);
        end
        return n;
    endfunction

endpackage

// File: rtl/alu16_iter_unit.sv
// Multi-cycle engine for GCD (binary Stein), LCM via (a/gcd)*b, and MSB-first square-and-multiply POW.
module alu16_iter_unit
    import alu16_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  opcode_e     op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        done,
    output logic [15:0] res,
    output logic        ovf
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StGcdRun = 3'd1;
    localparam logic [2:0] StLcmMul = 3'd2;
    localparam logic [2:0] StPowRun = 3'd3;
    localparam logic [2:0] StDone   = 3'd4;

    logic [2:0]  state_q, state_d;
    opcode_e     op_q, op_d;
    logic [15:0] a_q, a_d, b_q, b_d;
    logic [15:0] u_q, u_d, v_q, v_d;
    logic [3:0]  k_q, k_d, cnt_q, cnt_d;
    logic [15:0] res_q, res_d;
    logic        ovf_q, ovf_d;

    logic [3:0]  ctz_a, ctz_b, ctz_diff;
    logic [15:0] lo, hi, diff, quot;
    logic [31:0] sq, mulp, lcm_p;

    always_comb begin
        ctz_a    = ctz16(a);
        ctz_b    = ctz16(b);
        lo       = (u_q < v_q) ? u_q : v_q;
        hi       = (u_q < v_q) ? v_q : u_q;
        diff     = hi - lo;
        ctz_diff = ctz16(diff);
        sq       = {16'd0, res_q} * {16'd0, res_q};
        mulp     = {16'd0, sq[15:0]} * {16'd0, a_q};
        quot     = (u_q == 16'd0) ? 16'd0 : a_q / u_q;
        lcm_p    = {16'd0, quot} * {16'd0, b_q};
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        u_d     = u_q;
        v_d     = v_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    a_d   = a;
                    b_d   = b;
                    op_d  = op;
                    ovf_d = 1'b0;
                    if (op == OpPow) begin
                        res_d   = 16'd1;
                        cnt_d   = 4'd15;
                        state_d = StPowRun;
                    end else if (a == 16'd0 || b == 16'd0) begin
                        res_d   = (op == OpGcd) ? (a | b) : 16'd0;
                        state_d = StDone;
                    end else begin
                        // Strip factors of two up front; the common power is restored at the end.
                        u_d     = a >> ctz_a;
                        v_d     = b >> ctz_b;
                        k_d     = (ctz_a < ctz_b) ? ctz_a : ctz_b;
                        state_d = StGcdRun;
                    end
                end
            end
            StGcdRun: begin
                if (v_q == 16'd0) begin
                    u_d     = u_q << k_q;
                    res_d   = u_q << k_q;
                    state_d = (op_q == OpLcm) ? StLcmMul : StDone;
                end else begin
                    u_d = lo;
                    v_d = diff >> ctz_diff;
                end
            end
            StLcmMul: begin
                res_d   = lcm_p[15:0];
                ovf_d   = |lcm_p[31:16];
                state_d = StDone;
            end
            StPowRun: begin
                if (b_q[cnt_q]) begin
                    res_d = mulp[15:0];
                    ovf_d = ovf_q | (|sq[31:16]) | (|mulp[31:16]);
                end else begin
                    res_d = sq[15:0];
                    ovf_d = ovf_q | (|sq[31:16]);
                end
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd0) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= OpGcd;
            a_q     <= 16'd0;
            b_q     <= 16'd0;
            u_q     <= 16'd0;
            v_q     <= 16'd0;
            k_q     <= 4'd0;
            cnt_q   <= 4'd0;
            res_q   <= 16'd0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            u_q     <= u_d;
            v_q     <= v_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
        end
    end

    assign done = (state_q == StDone);
    assign res  = res_q;
    assign ovf  = ovf_q;

endmodule

// File: rtl/alu_16bit_extended.sv
// Clocked 16-bit ALU: single-cycle datapath plus an iterative unit for GCD/LCM/POW.
module alu_16bit_extended
    import alu16_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [7:0]       operation,
    output logic             busy,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
);

    opcode_e            op;
    logic               accept, is_iter, iter_done, iter_ovf;
    logic [15:0]        iter_res;
    logic [15:0]        a, b;
    logic [3:0]         amt;
    logic [2:0]         tidx;
    logic [16:0]        add_w, shl_w, shr_w;
    logic signed [16:0] asr_w;
    logic [31:0]        mul_w;
    logic [15:0]        alu_res;
    logic               alu_c;

    logic [15:0] result_q, result_d;
    logic        carry_q, carry_d, out_valid_q, out_valid_d, busy_q, busy_d;

    assign op        = opcode_e'(operation);
    assign a         = operand_a;
    assign b         = operand_b;
    assign amt       = b[3:0];
    assign tidx      = trig_index(a);
    assign is_iter   = (op == OpGcd) || (op == OpLcm) || (op == OpPow);
    assign accept    = in_valid && !busy_q;

    assign add_w = {1'b0, a} + {1'b0, b};
    assign mul_w = {16'd0, a} * {16'd0, b};
    // The extra bit on each shift captures the last bit shifted out.
    assign shl_w = {1'b0, a} << amt;
    assign shr_w = {a, 1'b0} >> amt;
    assign asr_w = $signed({a, 1'b0}) >>> amt;

    always_comb begin
        alu_res = 16'd0;
        alu_c   = 1'b0;
        case (op)
            OpAdd:  begin alu_res = add_w[15:0];  alu_c = add_w[16]; end
            OpSub:  begin alu_res = a - b;        alu_c = (a < b); end
            OpMul:  begin alu_res = mul_w[15:0];  alu_c = |mul_w[31:16]; end
            OpDiv:  begin
                alu_res = (b == 16'd0) ? 16'hFFFF : a / b;
                alu_c   = (b == 16'd0);
            end
            OpMod:  begin
                alu_res = (b == 16'd0) ? 16'hFFFF : a % b;
                alu_c   = (b == 16'd0);
            end
            OpAnd, OpAndAlias: alu_res = a & b;
            OpOr, OpOrAlias:   alu_res = a | b;
            OpXor:     alu_res = a ^ b;
            OpNor:     alu_res = ~(a | b);
            OpNand:    alu_res = ~(a & b);
            OpXnor:    alu_res = ~(a ^ b);
            OpGt:      alu_res = {15'd0, a > b};
            OpEq:      alu_res = {15'd0, a == b};
            OpLt:      alu_res = {15'd0, a < b};
            OpHamming: alu_res = {11'd0, pop16(a ^ b)};
            OpShl:  begin alu_res = shl_w[15:0];  alu_c = shl_w[16]; end
            OpShr:  begin alu_res = shr_w[16:1];  alu_c = shr_w[0]; end
            OpAsr:  begin alu_res = asr_w[16:1];  alu_c = asr_w[0]; end
            OpMaskHi:  alu_res = a & 16'hFF00;
            OpSetLo:   alu_res = a | 16'h00FF;
            OpFlipAlt: alu_res = a ^ 16'hAAAA;
            OpInc:  begin alu_res = a + 16'd1;    alu_c = (a == 16'hFFFF); end
            OpDec:  begin alu_res = a - 16'd1;    alu_c = (a == 16'd0); end
            OpAbs:  begin
                alu_res = a[15] ? (16'd0 - a) : a;
                alu_c   = (a == 16'h8000);
            end
            OpSin:  alu_res = SinLut[tidx];
            OpCos:  alu_res = SinLut[3'd6 - tidx];
            OpTan:  begin alu_res = TanLut[tidx]; alu_c = (tidx >= 3'd5); end
            default: ;
        endcase
    end

    alu16_iter_unit u_iter (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept && is_iter),
        .op    (op),
        .a     (a),
        .b     (b),
        .done  (iter_done),
        .res   (iter_res),
        .ovf   (iter_ovf)
    );

    always_comb begin
        result_d    = result_q;
        carry_d     = carry_q;
        out_valid_d = 1'b0;
        busy_d      = busy_q;
        if (iter_done) begin
            result_d    = iter_res;
            carry_d     = iter_ovf;
            out_valid_d = 1'b1;
            busy_d      = 1'b0;
        end else if (accept) begin
            if (is_iter) begin
                busy_d = 1'b1;
            end else begin
                result_d    = alu_res;
                carry_d     = alu_c;
                out_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q    <= 16'd0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            result_q    <= result_d;
            carry_q     <= carry_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign result    = result_q;
    assign carry_out = carry_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_alu_16bit_extended.sv
// Directed plus randomized bench for alu_16bit_extended against an arithmetic reference model.
module tb_alu_16bit_extended;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] operand_a, operand_b;
    logic [7:0]  operation;
    logic        busy, out_valid, carry_out;
    logic [15:0] result;

    int n_checks = 0;
    int n_errors = 0;

    alu_16bit_extended #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .operation (operation),
        .busy      (busy),
        .out_valid (out_valid),
        .result    (result),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: results straight from the arithmetic definition of each opcode.
    task automatic ref_op(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] r, output logic c);
        int     ua, ub, sa, n, t, t2, x, y, ang, idx;
        longint p;
        int     sin_t [7] = '{0, 4240, 8192, 11585, 14189, 15826, 16384};
        int     tan_t [5] = '{0, 4390, 9459, 16384, 28378};
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        n  = ub % 16;
        r  = 16'd0;
        c  = 1'b0;
        case (op)
            8'h00: begin t = ua + ub; r = t[15:0]; c = (t > 65535); end
            8'h01: begin t = ua - ub; r = t[15:0]; c = (ua < ub); end
            8'h02: begin p = longint'(ua) * ub; r = p[15:0]; c = (p > 65535); end
            8'h03: if (ub == 0) begin r = 16'hFFFF; c = 1'b1; end
                   else begin t = ua / ub; r = t[15:0]; end
            8'h04: if (ub == 0) begin r = 16'hFFFF; c = 1'b1; end
                   else begin t = ua % ub; r = t[15:0]; end
            8'h08, 8'h3C: r = a & b;
            8'h09, 8'h3D: r = a | b;
            8'h0A: r = a ^ b;
            8'h0B: r = ~(a | b);
            8'h0C: r = ~(a & b);
            8'h0D: r = ~(a ^ b);
            8'h10: r = (ua > ub) ? 16'd1 : 16'd0;
            8'h11: r = (ua == ub) ? 16'd1 : 16'd0;
            8'h12: r = (ua < ub) ? 16'd1 : 16'd0;
            8'h26, 8'h27: begin
                x = ua; y = ub;
                while (y != 0) begin t = x % y; x = y; y = t; end
                if (op == 8'h26) r = x[15:0];
                else if (ua != 0 && ub != 0) begin
                    p = longint'(ua / x) * ub;
                    r = p[15:0];
                    c = (p > 65535);
                end
            end
            8'h28: begin
                t = 0;
                for (int i = 0; i < 16; i++) if (a[i] != b[i]) t++;
                r = t[15:0];
            end
            8'h30: begin t = ua * (1 << n); r = t[15:0]; c = (n != 0) && t[16]; end
            8'h31: begin t = ua >> n; r = t[15:0]; c = (n != 0) && ((ua >> (n - 1)) % 2 == 1); end
            8'h32: begin
                t = sa >>> n; r = t[15:0];
                t2 = (n == 0) ? 0 : (sa >>> (n - 1));
                c = (n != 0) && t2[0];
            end
            8'h38: r = a & 16'hFF00;
            8'h39: r = a | 16'h00FF;
            8'h3A: r = a ^ 16'hAAAA;
            8'h40: begin t = ua + 1; r = t[15:0]; c = (ua == 65535); end
            8'h41: begin t = ua - 1; r = t[15:0]; c = (ua == 0); end
            8'h50: begin t = (sa < 0) ? -sa : sa; r = t[15:0]; c = (sa == -32768); end
            8'h51: begin
                p = 1;
                for (int i = 0; i < ub; i++) begin
                    p = p * ua;
                    if (p > 65535) begin c = 1'b1; p = p % 65536; end
                end
                r = p[15:0];
            end
            8'h52, 8'h53, 8'h54: begin
                ang = (ua > 90) ? 90 : ua;
                idx = ang / 15;
                if (op == 8'h52) t = sin_t[idx];
                else if (op == 8'h53) t = sin_t[6 - idx];
                else if (idx >= 5) begin t = 32767; c = 1'b1; end
                else t = tan_t[idx];
                r = t[15:0];
            end
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] er, input logic ec, input bit poke);
        int lat;
        bit seen, iter;
        iter = (op == 8'h26) || (op == 8'h27) || (op == 8'h51);
        @(negedge clk);
        in_valid = 1'b1; operation = op; operand_a = a; operand_b = b;
        @(negedge clk);
        in_valid = 1'b0; operand_a = 16'($urandom); operand_b = 16'($urandom);
        lat  = 1;
        seen = out_valid;
        if (iter && !seen) check_eq($sformatf("busy op=%h", op), 32'(busy), 32'd1);
        while (!seen && lat < 60) begin
            // A request during busy must be dropped without disturbing the running op.
            if (poke && lat == 2) begin
                in_valid = 1'b1; operation = 8'h00; operand_a = 16'd1; operand_b = 16'd1;
            end
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
            seen = out_valid;
        end
        check_eq($sformatf("valid op=%h a=%h b=%h", op, a, b), 32'(seen), 32'd1);
        if (seen) begin
            check_eq($sformatf("result op=%h a=%h b=%h", op, a, b), 32'(result), 32'(er));
            check_eq($sformatf("carry op=%h a=%h b=%h", op, a, b), 32'(carry_out), 32'(ec));
            if (iter) check_eq($sformatf("latency<=40 op=%h", op), 32'(lat <= 40), 32'd1);
            else      check_eq($sformatf("latency op=%h", op), 32'(lat), 32'd1);
        end
        @(negedge clk);
        check_eq($sformatf("pulse op=%h", op), 32'({out_valid, busy}), 32'd0);
    endtask

    task automatic run_rand(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                            input bit poke);
        logic [15:0] er;
        logic        ec;
        ref_op(op, a, b, er, ec);
        run_op(op, a, b, er, ec, poke);
    endtask

    logic [7:0] op_list [$];

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        logic [7:0]  op;
        logic [15:0] a, b;
        rst_n = 1'b0; in_valid = 1'b0; operation = 8'h00; operand_a = 16'd0; operand_b = 16'd0;
        repeat (3) @(negedge clk);
        check_eq("reset result", 32'(result), 32'd0);
        check_eq("reset carry", 32'(carry_out), 32'd0);
        check_eq("reset flags", 32'({out_valid, busy}), 32'd0);
        rst_n = 1'b1;

        run_op(8'h00, 16'd100, 16'd200, 16'd300, 1'b0, 1'b0);
        run_op(8'h01, 16'd300, 16'd150, 16'd150, 1'b0, 1'b0);
        run_op(8'h01, 16'd5, 16'd7, 16'hFFFE, 1'b1, 1'b0);
        run_op(8'h00, 16'hFFFF, 16'd1, 16'd0, 1'b1, 1'b0);
        run_op(8'h02, 16'd12, 16'd12, 16'd144, 1'b0, 1'b0);
        run_op(8'h03, 16'd100, 16'd5, 16'd20, 1'b0, 1'b0);
        run_op(8'h04, 16'd100, 16'd6, 16'd4, 1'b0, 1'b0);
        run_op(8'h03, 16'd100, 16'd0, 16'hFFFF, 1'b1, 1'b0);
        run_op(8'h08, 16'hA5A5, 16'h5A5A, 16'h0000, 1'b0, 1'b0);
        run_op(8'h09, 16'hA5A5, 16'h5A5A, 16'hFFFF, 1'b0, 1'b0);
        run_op(8'h0A, 16'hA5A5, 16'h5A5A, 16'hFFFF, 1'b0, 1'b0);
        run_op(8'h0B, 16'hAAAA, 16'h5555, 16'h0000, 1'b0, 1'b0);
        run_op(8'h0C, 16'hAAAA, 16'h5555, 16'hFFFF, 1'b0, 1'b0);
        run_op(8'h0D, 16'hAAAA, 16'h5555, 16'h0000, 1'b0, 1'b0);
        run_op(8'h28, 16'hAAAA, 16'h5555, 16'd16, 1'b0, 1'b0);
        run_op(8'h38, 16'hABCD, 16'd0, 16'hAB00, 1'b0, 1'b0);
        run_op(8'h39, 16'h1234, 16'd0, 16'h12FF, 1'b0, 1'b0);
        run_op(8'h3A, 16'h1234, 16'd0, 16'hB89E, 1'b0, 1'b0);
        run_op(8'h10, 16'd20, 16'd10, 16'd1, 1'b0, 1'b0);
        run_op(8'h11, 16'd50, 16'd50, 16'd1, 1'b0, 1'b0);
        run_op(8'h12, 16'd10, 16'd20, 16'd1, 1'b0, 1'b0);
        run_op(8'h30, 16'h00F0, 16'd4, 16'h0F00, 1'b0, 1'b0);
        run_op(8'h30, 16'h8001, 16'd1, 16'h0002, 1'b1, 1'b0);
        run_op(8'h31, 16'hF000, 16'd4, 16'h0F00, 1'b0, 1'b0);
        run_op(8'h32, 16'hFFF8, 16'd2, 16'hFFFE, 1'b0, 1'b0);
        run_op(8'h26, 16'd36, 16'd60, 16'd12, 1'b0, 1'b1);
        run_op(8'h27, 16'd6, 16'd8, 16'd24, 1'b0, 1'b1);
        run_op(8'h51, 16'd2, 16'd4, 16'd16, 1'b0, 1'b1);
        run_op(8'h51, 16'd2, 16'd16, 16'd0, 1'b1, 1'b0);
        run_op(8'h51, 16'd7, 16'd0, 16'd1, 1'b0, 1'b0);
        run_op(8'h26, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);
        run_op(8'h26, 16'd0, 16'd9, 16'd9, 1'b0, 1'b0);
        run_op(8'h27, 16'd0, 16'd5, 16'd0, 1'b0, 1'b0);
        run_op(8'h40, 16'd100, 16'd0, 16'd101, 1'b0, 1'b0);
        run_op(8'h41, 16'd100, 16'd0, 16'd99, 1'b0, 1'b0);
        run_op(8'h40, 16'hFFFF, 16'd0, 16'd0, 1'b1, 1'b0);
        run_op(8'h41, 16'd0, 16'd0, 16'hFFFF, 1'b1, 1'b0);
        run_op(8'h50, 16'hFB2E, 16'd0, 16'd1234, 1'b0, 1'b0);
        run_op(8'h50, 16'h8000, 16'd0, 16'h8000, 1'b1, 1'b0);
        run_op(8'h52, 16'd45, 16'd0, 16'd11585, 1'b0, 1'b0);
        run_op(8'h53, 16'd60, 16'd0, 16'd8192, 1'b0, 1'b0);
        run_op(8'h54, 16'd30, 16'd0, 16'd9459, 1'b0, 1'b0);
        run_op(8'h54, 16'd75, 16'd0, 16'h7FFF, 1'b1, 1'b0);
        run_op(8'hFF, 16'd3, 16'd4, 16'd0, 1'b0, 1'b0);

        // Abort a long GCD with reset: outputs clear and the aborted op never completes.
        run_op(8'h00, 16'd1, 16'd2, 16'd3, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b1; operation = 8'h26; operand_a = 16'hFFFF; operand_b = 16'd1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("busy before abort", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("abort result", 32'(result), 32'd0);
        check_eq("abort carry", 32'(carry_out), 32'd0);
        check_eq("abort flags", 32'({out_valid, busy}), 32'd0);
        pulses = 0;
        repeat (50) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check_eq("abort no out_valid", 32'(pulses), 32'd0);

        op_list = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C,
                    8'h0D, 8'h10, 8'h11, 8'h12, 8'h26, 8'h27, 8'h28, 8'h30, 8'h31, 8'h32,
                    8'h38, 8'h39, 8'h3A, 8'h3C, 8'h3D, 8'h40, 8'h41, 8'h50, 8'h51, 8'h52,
                    8'h53, 8'h54};
        for (int i = 0; i < 250; i++) begin
            op = op_list[$urandom_range(0, op_list.size() - 1)];
            if ($urandom_range(0, 9) == 0) op = 8'($urandom);
            a = 16'($urandom);
            b = 16'($urandom);
            if ($urandom_range(0, 3) == 0) b = 16'($urandom_range(0, 3));
            if (op >= 8'h52 && op <= 8'h54 && $urandom_range(0, 3) != 0)
                a = 16'($urandom_range(0, 120));
            if (op == 8'h51 && $urandom_range(0, 3) != 0) begin
                a = 16'($urandom_range(0, 12));
                b = 16'($urandom_range(0, 20));
            end
            run_rand(op, a, b, ($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
